dmem_ws: RTL and testbench
==========================

// Module: dmem_ws
// PURPOSE
//  Parametrised wait-state data memory; successor to the zero-latency word-only dmem.
//  Serves the processor's load/store port over a req/ready handshake with configurable latency.
//  Adds byte-lane access (LDRB/STRB) and error reporting for misaligned or out-of-range addresses.
//  Sits between the core's ALUResult/WriteData path and data storage; the core stalls while busy=1.
// PARAMETERS
//  DEPTH_WORDS  64   number of 32-bit words; legal word index 0..DEPTH_WORDS-1
//  WAIT_CYCLES  2    extra wait states per access, 0..15
//  INIT_FILE    ""   hex file loaded with $readmemh at elaboration; "" means no preload
// PORTS
//  clk    in   1   single clock; all state updates on the rising edge
//  reset  in   1   asynchronous, active-low reset (0 = in reset)
//  req    in   1   access request; sampled only when busy=0
//  we     in   1   1 = store, 0 = load; sampled with req
//  size   in   1   0 = word, 1 = byte; sampled with req
//  a      in   32  byte address; sampled with req
//  wd     in   32  store data; byte store uses wd[7:0]; sampled with req
//  rd     out  32  load data; valid only while ready=1
//  ready  out  1   one-cycle completion pulse
//  busy   out  1   1 from the acceptance edge until the cycle after ready
//  err    out  1   valid with ready: 1 = access rejected
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE, cnt=0, rd=0, ready=0, busy=0, err=0.
//   Memory array is NOT cleared. Reset during WAIT aborts the access; no write is committed.
//  FSM states: IDLE, WAIT, DONE; busy = (state != IDLE); ready = (state == DONE).
//  IDLE: at an edge with req=1, latch we/size/a/wd.
//   WAIT_CYCLES=0 -> DONE; otherwise -> WAIT with cnt = WAIT_CYCLES-1.
//  WAIT: at each edge, cnt==0 -> DONE, else cnt <= cnt-1.
//  DONE: lasts exactly one cycle, then -> IDLE. A new req is accepted at the earliest
//   at the first edge with state=IDLE again.
//  Latency: ready is high in the cycle following edge E0+WAIT_CYCLES, where E0 is the
//   acceptance edge. Throughput is one access per WAIT_CYCLES+2 cycles.
//  req while busy=1 is ignored (not queued); latched fields stay stable until DONE.
//  Error check on latched a: word access with a[1:0]!=0, or a[31:2] >= DEPTH_WORDS.
//   Error -> err=1 and rd=0 in DONE; memory unmodified.
//  Commit: the memory write and rd capture occur on the edge entering DONE.
//   Word store: mem[a[31:2]] <= wd.
//   Byte store: only lane a[1:0] of mem[a[31:2]] <= wd[7:0] (little-endian); other lanes kept.
//   Word load: rd = mem[a[31:2]].
//   Byte load: rd = {24'b0, lane a[1:0]} (zero-extended).
//   Store: rd = 0.
//  Outside DONE: rd=0, err=0.
//  Address bits above the index range are not wrapped; they produce err.
// TESTING
//  1 Hold reset=0 mid-WAIT of a store 0x1 to 0x04 -> ready/busy/err/rd=0; later load 0x04
//    returns the prior value.
//  2 WAIT_CYCLES=2: word store 0xDEADBEEF @0x20, then load @0x20 -> ready 3 cycles after
//    accept cycle, rd=0xDEADBEEF, err=0.
//  3 Word 0x11223344 @0x20; byte store 0xAA @0x21 -> word load gives 0x1122AA44;
//    byte load @0x23 gives 0x00000011.
//  4 Word store @0x22 -> err=1, rd=0; word @0x20 unchanged.
//    Load @0x100 (DEPTH 64) -> err=1.
//  5 req held high for 10 cycles -> exactly one access per WAIT_CYCLES+2 cycles;
//    req pulsed while busy -> dropped.
//  6 WAIT_CYCLES=0 build: load accepted at edge E0 -> ready=1 in the next cycle,
//    busy=0 the cycle after.

Source files
------------

// File: rtl/dmem_ws.sv
// Wait-state data memory: word/byte load-store over a req/ready handshake with error reporting.
// Latency WAIT_CYCLES+1 edges from acceptance to ready; req is ignored (not queued) while busy.
module dmem_ws #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        we_q, size_q;
    logic [31:0] a_q, wd_q;

    logic        acc_we, acc_size, acc_err, accept, commit;
    logic [31:0] acc_a, acc_wd, load_dat;
    logic [AW-1:0] idx;
    logic [1:0]  lane;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the access commits on its acceptance edge, so the
    // live inputs are used in IDLE and the latched copy everywhere else.
    always_comb begin
        acc_we   = (state == IDLE) ? we   : we_q;
        acc_size = (state == IDLE) ? size : size_q;
        acc_a    = (state == IDLE) ? a    : a_q;
        acc_wd   = (state == IDLE) ? wd   : wd_q;
        lane     = acc_a[1:0];
        idx      = acc_a[AW+1:2];
        acc_err  = (!acc_size && (lane != 2'b00)) ||
                   ({2'b00, acc_a[31:2]} >= 32'(DEPTH_WORDS));
        accept   = (state == IDLE) && req;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_dat = 32'd0;
        if (!acc_err && !acc_we) begin
            if (acc_size) load_dat = {24'd0, mem[idx][{lane, 3'b000} +: 8]};
            else          load_dat = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            rd     <= 32'd0;
            err    <= 1'b0;
            we_q   <= 1'b0;
            size_q <= 1'b0;
            a_q    <= 32'd0;
            wd_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q   <= we;
                size_q <= size;
                a_q    <= a;
                wd_q   <= wd;
            end
            if (commit) begin
                rd  <= load_dat;
                err <= acc_err;
            end else begin
                rd  <= 32'd0;
                err <= 1'b0;
            end
        end
    end

    // Storage has no reset; gating on reset keeps an aborted access from writing.
    always_ff @(posedge clk) begin
        if (reset && commit && acc_we && !acc_err) begin
            if (acc_size) mem[idx][{lane, 3'b000} +: 8] <= acc_wd[7:0];
            else          mem[idx] <= acc_wd;
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_ws.sv
// Bench for dmem_ws: transaction-level memory model checked every cycle, plus directed literal cases.
module tb_dmem_ws;
    localparam int W     = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0, reset = 1'b0, req = 1'b0, req0 = 1'b0;
    logic        we = 1'b0, size = 1'b0;
    logic [31:0] a = 32'd0, wd = 32'd0;
    logic [31:0] rd, rd0;
    logic        ready, busy, err, ready0, busy0, err0;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dmem_ws #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .a(a), .wd(wd),
        .rd(rd), .ready(ready), .busy(busy), .err(err));

    dmem_ws #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .a(a), .wd(wd),
        .rd(rd0), .ready(ready0), .busy(busy0), .err(err0));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: age = cycles since acceptance (-1 idle); result appears at age W.
    int          age = -1;
    logic        m_we, m_size;
    logic [31:0] m_a, m_wd, exp_rd;
    logic        exp_err;
    logic [31:0] mem_m [DEPTH];
    bit          chk_en = 1'b0;

    task automatic model_commit();
        logic [5:0] widx;
        int         sh;
        exp_err = (!m_size && (m_a % 4 != 0)) || (m_a / 4 >= 32'(DEPTH));
        exp_rd  = 32'd0;
        if (!exp_err) begin
            widx = m_a[7:2];
            sh   = 8 * int'(m_a[1:0]);
            if (m_we) begin
                if (m_size) mem_m[widx] = (mem_m[widx] & ~(32'hFF << sh)) | ({24'd0, m_wd[7:0]} << sh);
                else        mem_m[widx] = m_wd;
            end else if (m_size) exp_rd = (mem_m[widx] >> sh) & 32'hFF;
            else                 exp_rd = mem_m[widx];
        end
    endtask

    always @(posedge clk) begin
        if (!reset) age = -1;
        else if (age < 0) begin
            if (req) begin
                m_we = we; m_size = size; m_a = a; m_wd = wd;
                age = 0;
                if (W == 0) model_commit();
            end
        end else if (age == W) age = -1;
        else begin
            age = age + 1;
            if (age == W) model_commit();
        end
    end

    always @(negedge clk) begin
        logic e_rdy;
        if (chk_en) begin
            e_rdy = reset && (age == W);
            check("busy", {31'd0, busy}, {31'd0, reset && (age >= 0)});
            check("ready", {31'd0, ready}, {31'd0, e_rdy});
            check("err", {31'd0, err}, {31'd0, e_rdy && exp_err});
            check("rd", rd, e_rdy ? exp_rd : 32'd0);
        end
    end

    // One access on dut (sel=0) or dut0 (sel=1); lat = edges after acceptance before ready.
    task automatic acc(input bit sel, input logic we_i, input logic size_i, input logic [31:0] a_i,
                       input logic [31:0] wd_i, output logic [31:0] rdv, output logic errv,
                       output int lat, output logic busy_after);
        bit found = 1'b0;
        rdv = 32'd0; errv = 1'b0; lat = 0; busy_after = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < 50 && (sel ? busy0 : busy); i++) begin
            @(posedge clk); #2;
        end
        we = we_i; size = size_i; a = a_i; wd = wd_i;
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0; req0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel ? ready0 : ready) begin
                found = 1'b1;
                rdv   = sel ? rd0 : rd;
                errv  = sel ? err0 : err;
                break;
            end
            lat++;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL acc_timeout: no ready within 40 cycles, addr %h", a_i);
        end
        @(negedge clk);
        busy_after = sel ? busy0 : busy;
    endtask

    initial begin
        logic [31:0] rv;
        logic        ev, bav;
        int          lat, n, r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rd", rd, 32'd0);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) acc(0, 1'b1, 1'b0, 32'(i * 4), $urandom, rv, ev, lat, bav);

        // Reset mid-WAIT aborts the store.
        acc(0, 1'b1, 1'b0, 32'h04, 32'hCAFEF00D, rv, ev, lat, bav);
        @(posedge clk); #2;
        req = 1'b1; we = 1'b1; size = 1'b0; a = 32'h04; wd = 32'h1;
        @(posedge clk); #2;
        req = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_rd", rd, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        acc(0, 1'b0, 1'b0, 32'h04, 32'd0, rv, ev, lat, bav);
        check("abort_keep", rv, 32'hCAFEF00D);

        acc(0, 1'b1, 1'b0, 32'h20, 32'hDEADBEEF, rv, ev, lat, bav);
        acc(0, 1'b0, 1'b0, 32'h20, 32'd0, rv, ev, lat, bav);
        check("ld_word", rv, 32'hDEADBEEF);
        check("ld_err", {31'd0, ev}, 32'd0);
        check("ld_lat", 32'(lat), 32'd2);
        check("ld_busy_after", {31'd0, bav}, 32'd0);

        acc(0, 1'b1, 1'b0, 32'h20, 32'h11223344, rv, ev, lat, bav);
        acc(0, 1'b1, 1'b1, 32'h21, 32'h000000AA, rv, ev, lat, bav);
        acc(0, 1'b0, 1'b0, 32'h20, 32'd0, rv, ev, lat, bav);
        check("strb_word", rv, 32'h1122AA44);
        acc(0, 1'b0, 1'b1, 32'h23, 32'd0, rv, ev, lat, bav);
        check("ldrb_lane3", rv, 32'h00000011);

        acc(0, 1'b1, 1'b0, 32'h22, 32'h55555555, rv, ev, lat, bav);
        check("misal_err", {31'd0, ev}, 32'd1);
        check("misal_rd", rv, 32'd0);
        acc(0, 1'b0, 1'b0, 32'h20, 32'd0, rv, ev, lat, bav);
        check("misal_keep", rv, 32'h1122AA44);
        acc(0, 1'b0, 1'b0, 32'h100, 32'd0, rv, ev, lat, bav);
        check("oor_err", {31'd0, ev}, 32'd1);

        // req held for 10 edges: accepts at edges 1, 5, 9.
        n = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #2;
            req = (i < 10); we = 1'b0; size = 1'b0; a = 32'h20;
            @(negedge clk);
            if (ready) n++;
        end
        check("hold_count", 32'(n), 32'd3);
        // Second pulse lands while busy and is dropped.
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            req = (i == 0 || i == 2);
            @(negedge clk);
            if (ready) n++;
        end
        check("drop_count", 32'(n), 32'd1);

        acc(1, 1'b1, 1'b0, 32'h08, 32'h12345678, rv, ev, lat, bav);
        acc(1, 1'b0, 1'b0, 32'h08, 32'd0, rv, ev, lat, bav);
        check("w0_rd", rv, 32'h12345678);
        check("w0_lat", 32'(lat), 32'd0);
        check("w0_busy_after", {31'd0, bav}, 32'd0);
        acc(1, 1'b0, 1'b0, 32'h09, 32'd0, rv, ev, lat, bav);
        check("w0_misal_err", {31'd0, ev}, 32'd1);

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #2;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            req  = ($urandom_range(0, 2) == 0);
            we   = 1'($urandom);
            size = 1'($urandom);
            r    = int'($urandom_range(0, 9));
            if (r == 0) a = $urandom;
            else begin
                a = {24'd0, 8'($urandom)};
                if (!size && r > 2) a[1:0] = 2'b00;
            end
            wd = $urandom;
        end
        @(posedge clk); #2;
        req = 1'b0; reset = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
